// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter between N_REQ
// byte producers. A granted byte is loaded into the uart, and then the arbiter
// waits for a full frame time, because the uart gives no busy indication.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int FRAME_CYC_0 = 104170,
    parameter int FRAME_CYC_1 = 8681
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic                     baud_sel,
    output logic [N_REQ-1:0]         gnt,
    output logic [7:0]               uart_tx_data,
    output logic                     uart_load,
    output logic                     uart_sel,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] last_id
);

    localparam int ID_W      = $clog2(N_REQ);
    localparam int FRAME_MAX = (FRAME_CYC_0 > FRAME_CYC_1) ? FRAME_CYC_0 : FRAME_CYC_1;
    localparam int CNT_W     = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD_0 = CNT_W'(FRAME_CYC_0 - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD_1 = CNT_W'(FRAME_CYC_1 - 1);
    localparam logic [ID_W-1:0]  LAST_RST   = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [7:0]        data_q, data_d;
    logic              load_q, load_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        data_arr [N_REQ];
    logic              win_found;
    logic [ID_W-1:0]   win_idx;

    // Unpack the flat byte bus so the winner's byte can be picked by index.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            data_arr[k] = req_data[8*k +: 8];
        end
    end

    // Round-robin search starting just after the last granted requester; the
    // last winner is therefore checked last.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand     = (int'(last_id_q) + i) % N_REQ;
            cand_idx = cand[ID_W-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and registered-output logic; the grant, load strobe and byte
    // are set up on the IDLE->LOAD edge so they are visible during LOAD.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        load_d    = 1'b0;
        data_d    = data_q;
        sel_d     = sel_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                sel_d = baud_sel;
                if (win_found) begin
                    state_d          = ST_LOAD;
                    gnt_d[win_idx]   = 1'b1;
                    load_d           = 1'b1;
                    data_d           = data_arr[win_idx];
                    last_id_d        = win_idx;
                end
            end
            ST_LOAD: begin
                cnt_d   = sel_q ? CNT_LOAD_1 : CNT_LOAD_0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            data_q    <= 8'h00;
            load_q    <= 1'b0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            last_id_q <= LAST_RST;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            data_q    <= data_d;
            load_q    <= load_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign uart_tx_data = data_q;
    assign uart_load    = load_q;
    assign uart_sel     = sel_q;
    assign busy         = busy_q;
    assign last_id      = last_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed steps in one initial block, a
// scoreboard queue of expected loads checked by a monitor on each uart_load.
module tb_uart_tx_arbiter;

    localparam int N_REQ       = 4;
    localparam int FRAME_CYC_0 = 20;
    localparam int FRAME_CYC_1 = 6;

    logic        clk;
    logic        n_rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        baud_sel;
    logic [3:0]  gnt;
    logic [7:0]  uart_tx_data;
    logic        uart_load;
    logic        uart_sel;
    logic        busy;
    logic [1:0]  last_id;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
        logic       sel;
        logic [1:0] id;
        int         gap;
    } exp_t;

    exp_t sb_q[$];
    int   assert_count   = 0;
    int   fail_count     = 0;
    int   load_count     = 0;
    int   cycle_count    = 0;
    int   last_load_cyc  = 0;
    int   release_cyc    = 0;
    int   drive_cyc      = 0;
    int   busy_cycles    = 0;

    uart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .FRAME_CYC_0 (FRAME_CYC_0),
        .FRAME_CYC_1 (FRAME_CYC_1)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req          (req),
        .req_data     (req_data),
        .baud_sel     (baud_sel),
        .gnt          (gnt),
        .uart_tx_data (uart_tx_data),
        .uart_load    (uart_load),
        .uart_sel     (uart_sel),
        .busy         (busy),
        .last_id      (last_id)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure load spacing and latency.
    always @(posedge clk) begin
        cycle_count <= cycle_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive request/baud inputs just after a rising edge.
    task automatic applyStimulus(input logic [3:0] r, input logic b);
        @(posedge clk);
        #1;
        req       = r;
        baud_sel  = b;
        drive_cyc = cycle_count;
    endtask

    task automatic pushExp(input logic [3:0] g, input logic [7:0] d, input logic s, input logic [1:0] id, input int gap);
        exp_t e;
        e.gnt  = g;
        e.data = d;
        e.sel  = s;
        e.id   = id;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    task automatic waitLoads(input int target, input int budget);
        int n;
        n = 0;
        while (load_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("load_wait", load_count, target);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < budget);
        checkOutput("idle_wait", busy, 0);
    endtask

    // Monitor: every uart_load pops one expected transaction.
    always @(negedge clk) begin
        if (uart_load === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_load", uart_load, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("load_gnt", gnt, e.gnt);
                checkOutput("load_data", uart_tx_data, e.data);
                checkOutput("load_sel", uart_sel, e.sel);
                checkOutput("load_id", last_id, e.id);
                checkOutput("load_busy", busy, 1);
                if (e.gap != 0) begin
                    checkOutput("load_gap", cycle_count - last_load_cyc, e.gap);
                end
            end
            last_load_cyc = cycle_count;
            load_count++;
        end else if (uart_load === 1'b0 && n_rst === 1'b1 && gnt !== 4'b0000) begin
            checkOutput("gnt_without_load", gnt, 0);
        end
    end

    initial begin
        n_rst    = 1'b0;
        req      = 4'hF;
        baud_sel = 1'b0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held with all requests pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_load", uart_load, 0);
        checkOutput("rst_data", uart_tx_data, 8'h00);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_last_id", last_id, 3);
        checkOutput("rst_sel", uart_sel, 0);

        // Round robin with all requests held: 0,1,2,3,0, FRAME_CYC_0+2 apart.
        pushExp(4'b0001, 8'h11, 1'b0, 2'd0, 0);
        pushExp(4'b0010, 8'h22, 1'b0, 2'd1, FRAME_CYC_0 + 2);
        pushExp(4'b0100, 8'h33, 1'b0, 2'd2, FRAME_CYC_0 + 2);
        pushExp(4'b1000, 8'h44, 1'b0, 2'd3, FRAME_CYC_0 + 2);
        pushExp(4'b0001, 8'h11, 1'b0, 2'd0, FRAME_CYC_0 + 2);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        waitLoads(5, 200);
        #1;
        req = 4'h0;

        // Single requester: one-cycle latency and busy window of LOAD + WAIT.
        waitIdle(100);
        req_data[23:16] = 8'h92;
        pushExp(4'b0100, 8'h92, 1'b0, 2'd2, 0);
        applyStimulus(4'b0100, 1'b0);
        waitLoads(6, 10);
        checkOutput("single_latency", last_load_cyc - drive_cyc, 1);
        #1;
        req = 4'h0;
        busy_cycles = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            busy_cycles++;
        end
        checkOutput("single_busy_len", busy_cycles, FRAME_CYC_0 + 1);

        // Fast baud: two back-to-back frames, then baud_sel toggled mid-WAIT.
        req_data[7:0] = 8'hA4;
        pushExp(4'b0001, 8'hA4, 1'b1, 2'd0, 0);
        pushExp(4'b0001, 8'hA4, 1'b1, 2'd0, FRAME_CYC_1 + 2);
        applyStimulus(4'b0001, 1'b1);
        waitLoads(8, 100);
        #1;
        req      = 4'h0;
        baud_sel = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            checkOutput("sel_hold_wait", uart_sel, 1);
        end
        checkOutput("sel_idle_reached", busy, 0);
        checkOutput("sel_first_idle", uart_sel, 1);
        @(negedge clk);
        checkOutput("sel_updated", uart_sel, 0);

        // Reset in the middle of a frame, with requester 1 pending.
        req_data[7:0] = 8'h5A;
        pushExp(4'b0001, 8'h5A, 1'b0, 2'd0, 0);
        applyStimulus(4'b0001, 1'b0);
        waitLoads(9, 10);
        #1;
        req              = 4'b0010;
        req_data[15:8]   = 8'hC3;
        repeat (9) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy_before", busy, 1);
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_load", uart_load, 0);
        checkOutput("midrst_gnt", gnt, 0);
        checkOutput("midrst_last_id", last_id, 3);
        checkOutput("midrst_data", uart_tx_data, 8'h00);
        pushExp(4'b0010, 8'hC3, 1'b0, 2'd1, 0);
        @(posedge clk);
        #1;
        n_rst       = 1'b1;
        release_cyc = cycle_count;
        waitLoads(10, 10);
        checkOutput("midrst_grant_latency", last_load_cyc - release_cyc, 1);

        // Withdrawn request: pulsed only during WAIT, never granted.
        #1;
        req = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        req = 4'b0010;
        repeat (3) @(posedge clk);
        #1;
        req = 4'h0;
        waitIdle(100);
        repeat (30) @(negedge clk);
        checkOutput("withdraw_loads", load_count, 10);
        checkOutput("withdraw_gnt", gnt, 0);
        checkOutput("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
